vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter CHARS, default 960, meaning number of character cells (40x24).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning VRAM address width.
REQ-003 SHALL have parameter DATA_W, default 6, meaning character code width.
REQ-004 SHALL have parameter CLR_CHAR, default 6'h20, meaning the code written by a clear sweep (space).
REQ-005 SHALL have port clk25, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port disp_req, input, 1, meaning the display fetch requests a read this cycle.
REQ-008 SHALL have port disp_addr, input, ADDR_W, meaning the display read address.
REQ-009 SHALL have port disp_valid, output, 1, meaning disp_data is valid this cycle.
REQ-010 SHALL have port disp_data, output, DATA_W, meaning the display read data.
REQ-011 SHALL have port wr_req, input, 1, meaning the terminal write request, held until acknowledged.
REQ-012 SHALL have port wr_addr, input, ADDR_W, meaning the terminal write address.
REQ-013 SHALL have port wr_data, input, DATA_W, meaning the terminal write character.
REQ-014 SHALL have port wr_ack, output, 1, meaning a one-cycle pulse that completes the terminal write.
REQ-015 SHALL have port cls, input, 1, meaning the clear-screen start pulse (level treated as repeated pulses).
REQ-016 SHALL have port cls_busy, output, 1, meaning a clear sweep is in progress.
REQ-017 SHALL have port cls_done, output, 1, meaning a one-cycle pulse after the last clear write.
REQ-018 SHALL have ports ram_addr (output, ADDR_W), ram_we (output, 1), ram_wdata (output, DATA_W) and ram_rdata (input, DATA_W), meaning the single-port VRAM with 1-cycle read latency.

Function
REQ-019 SHALL grant one requester per cycle with fixed priority: display > clear sweep > terminal write.
REQ-020 SHALL drive ram_addr, ram_we and ram_wdata combinationally from the current-cycle grant; with no grant, ram_we=0 and ram_addr=disp_addr.
REQ-021 SHALL, on a display grant, assert disp_valid exactly one cycle later with disp_data=ram_rdata; disp_data is don't-care when disp_valid=0.
REQ-022 SHALL implement FSM states IDLE and CLEAR: IDLE->CLEAR on cls; CLEAR->IDLE on the cycle after the write to address CHARS-1.
REQ-023 SHALL, in CLEAR, write CLR_CHAR at the sweep counter address on each cycle without disp_req, incrementing the counter only on those cycles.
REQ-024 SHALL hold the sweep counter without skipping addresses while display steals cycles.
REQ-025 SHALL restart the sweep at address 0 when cls is asserted in CLEAR; cls_done is then issued only at the end of the restarted sweep.
REQ-026 SHALL assert cls_busy in CLEAR only, and pulse cls_done for one cycle on the CLEAR->IDLE transition.
REQ-027 SHALL grant a terminal write only in IDLE with disp_req=0, asserting ram_we and wr_ack in the same cycle.
REQ-028 SHALL keep pending terminal writes stalled (wr_ack=0) throughout CLEAR.
REQ-029 SHALL, when cls and wr_req arrive in the same IDLE cycle, let the clear win; the write completes after cls_done.
REQ-030 SHALL acknowledge a terminal write with wr_addr>=CHARS without asserting ram_we.
REQ-031 SHALL never assert wr_ack in two consecutive cycles; the requester is expected to drop or change wr_req after wr_ack.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, enter IDLE with sweep counter 0, disp_valid=0, wr_ack=0, cls_busy=0 and cls_done=0.
REQ-033 SHALL abort a sweep in progress on reset without asserting cls_done; already-written cells keep their values.
REQ-034 SHALL hold ram_we=0 during any cycle in which rst=1.

Verification
REQ-035 SHALL cover display read: disp_req=1, disp_addr=10'd5, RAM[5]=6'h01 -> next cycle disp_valid=1, disp_data=6'h01.
REQ-036 SHALL cover contention: disp_req and wr_req (addr 7, data 6'h41) in the same cycle -> display granted; write lands and wr_ack pulses on the first cycle with disp_req=0.
REQ-037 SHALL cover a full clear with disp_req toggling 50% -> all 960 cells read 6'h20; cls_busy high for 960 granted write cycles plus stolen cycles; one cls_done pulse.
REQ-038 SHALL cover cls re-asserted at sweep address 500 -> sweep restarts at 0; exactly one cls_done, after address 959.
REQ-039 SHALL cover wr_req held during CLEAR -> no wr_ack until after cls_done; then written, so RAM[wr_addr]=wr_data overrides the space.
REQ-040 SHALL cover rst pulse mid-sweep at address 300 -> cls_busy=0 next cycle, no cls_done, cells 300..959 unchanged; wr_req with wr_addr=10'd1000 -> wr_ack with ram_we=0.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: shares one RAM port between display fetch, a
// clear-screen sweep and terminal character writes, in that priority order.
module vram_arbiter #(
  parameter int                CHARS    = 960,
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 6,
  parameter logic [DATA_W-1:0] CLR_CHAR = 6'h20
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              cls,
  output logic              cls_busy,
  output logic              cls_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] sweep_cnt_r;
  logic [ADDR_W-1:0] sweep_cnt_nxt_s;
  logic              disp_valid_r;
  logic              cls_done_r;
  logic              cls_done_nxt_s;
  logic              wr_ack_prev_r;
  logic              disp_gnt_s;
  logic              clr_gnt_s;
  logic              wr_gnt_s;
  logic              wr_in_range_s;
  logic              sweep_last_s;

  assign wr_in_range_s = (32'(wr_addr) < CHARS);
  assign sweep_last_s  = (sweep_cnt_r == ADDR_W'(CHARS - 1));

  // Fixed-priority grant; nothing is granted while reset is held.
  // A cls cycle (IDLE start or CLEAR restart) grants neither sweep nor write.
  always_comb begin
    disp_gnt_s = 1'b0;
    clr_gnt_s  = 1'b0;
    wr_gnt_s   = 1'b0;
    if (rst) begin
      disp_gnt_s = 1'b0;
    end else if (disp_req) begin
      disp_gnt_s = 1'b1;
    end else if (state_r == ST_CLEAR) begin
      if (!cls) begin
        clr_gnt_s = 1'b1;
      end else begin
        clr_gnt_s = 1'b0;
      end
    end else if (wr_req && !cls && !wr_ack_prev_r) begin
      wr_gnt_s = 1'b1;
    end else begin
      wr_gnt_s = 1'b0;
    end
  end

  // RAM port mux driven from the current-cycle grant.
  always_comb begin
    ram_addr  = disp_addr;
    ram_we    = 1'b0;
    ram_wdata = {DATA_W{1'b0}};
    if (clr_gnt_s) begin
      ram_addr  = sweep_cnt_r;
      ram_we    = 1'b1;
      ram_wdata = CLR_CHAR;
    end else if (wr_gnt_s) begin
      ram_addr  = wr_addr;
      ram_we    = wr_in_range_s;
      ram_wdata = wr_data;
    end else begin
      ram_we    = 1'b0;
    end
  end

  // Sweep FSM next state; counter advances only on cycles the sweep owns the port.
  always_comb begin
    state_nxt_s     = state_r;
    sweep_cnt_nxt_s = sweep_cnt_r;
    cls_done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cls) begin
          state_nxt_s     = ST_CLEAR;
          sweep_cnt_nxt_s = {ADDR_W{1'b0}};
        end else begin
          state_nxt_s     = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cls) begin
          sweep_cnt_nxt_s = {ADDR_W{1'b0}};
        end else if (clr_gnt_s && sweep_last_s) begin
          state_nxt_s     = ST_IDLE;
          sweep_cnt_nxt_s = {ADDR_W{1'b0}};
          cls_done_nxt_s  = 1'b1;
        end else if (clr_gnt_s) begin
          sweep_cnt_nxt_s = sweep_cnt_r + ADDR_W'(1);
        end else begin
          sweep_cnt_nxt_s = sweep_cnt_r;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        sweep_cnt_nxt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, sweep counter and registered status flags.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      sweep_cnt_r   <= {ADDR_W{1'b0}};
      disp_valid_r  <= 1'b0;
      cls_done_r    <= 1'b0;
      wr_ack_prev_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      sweep_cnt_r   <= sweep_cnt_nxt_s;
      disp_valid_r  <= disp_gnt_s;
      cls_done_r    <= cls_done_nxt_s;
      wr_ack_prev_r <= wr_gnt_s;
    end
  end

  assign wr_ack     = wr_gnt_s;
  assign disp_valid = disp_valid_r;
  assign disp_data  = ram_rdata;
  assign cls_busy   = (state_r == ST_CLEAR);
  assign cls_done   = cls_done_r;

endmodule
